// File: rtl/apb_completer_mem.sv
// apb_completer_mem: APB3 completer serving reads/writes from an internal register file.
// Optional wait states are enabled with the APB_WAIT_STATE_EN macro (WAIT_CYCLES per transfer);
// without it every transfer completes with zero wait states and no counter is built.
// state_q names the bus phase sampled on the last clock edge: SETUP means the SETUP phase was
// just captured (so the bus is now in its first ACCESS cycle), ACCESS means later ACCESS cycles.
module apb_completer_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              pready_q, pready_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;

    logic [ADDR_W-1:0] rd_addr;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;
    logic              wait_last;

`ifdef APB_WAIT_STATE_EN
    localparam int WAITS = WAIT_CYCLES;
    localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Last wait cycle reached: pready is raised on the coming edge.
    assign wait_last = (cnt_q == CW'(WAITS - 1));

    // Wait counter: cleared while idle (hence on every SETUP), counts stalled ACCESS cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (psel && penable && !pready_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    // WAIT_CYCLES has no effect in this build; every transfer is zero-wait.
    localparam int WAITS = (WAIT_CYCLES >= 0) ? 0 : 0;

    assign wait_last = 1'b1;
`endif

    // While idle the SETUP phase is on the bus right now, so decode the live address
    // (this is what makes zero-wait responses possible); afterwards use the latched one.
    assign rd_addr  = (state_q == IDLE) ? paddr : addr_q;
    assign in_range = (int'(rd_addr) < DEPTH);
    assign rd_word  = mem_q[rd_addr[IW-1:0]];

    // Next-state, latch and response logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // penable without a preceding SETUP phase is ignored.
                if (psel && !penable) begin
                    state_d = SETUP;
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    if (WAITS == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = !in_range;
                        prdata_d  = (!pwrite && in_range) ? rd_word : '0;
                    end
                end
            end
            SETUP, ACCESS: begin
                if (!psel || !penable) begin
                    // Requester abandoned the transfer: nothing committed, no response.
                    state_d = IDLE;
                end else if (pready_q) begin
                    // Completing edge; out-of-range writes are dropped.
                    state_d = IDLE;
                    mem_we  = write_q && !pslverr_q;
                end else begin
                    state_d = ACCESS;
                    if (wait_last) begin
                        pready_d  = 1'b1;
                        pslverr_d = !in_range;
                        prdata_d  = (!write_q && in_range) ? rd_word : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, latched request and registered response.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Register-file storage, cleared by reset, written on the completing edge.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[addr_q[IW-1:0]] <= wdata_q;
        end
    end

    assign pready  = pready_q;
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;

endmodule
